ntt_row_streamer: RTL and testbench
===================================

# ntt_row_streamer

Parametrised row-streaming front end for the non-power-of-two NTT core. It converts a word-serial valid/ready stream into full-width row writes on the core's lane-parallel memory port, and row reads back into a word-serial stream. It replaces bench-driven row loading and unloading, and sits between the host/DMA side and the `ntt` core's `mem_read`/`mem_write`/`mem_addr`/`din`/`dout` port. Commands select load or unload over a programmable row window.

## Interface
- `LANES`, 257, coefficients per row (lanes of the core)
- `ROWS`, 85, rows in the core memory
- `WIDTH`, 32, coefficient width
- `AW`, 8, per-lane row address width
- `READ_LAT`, 2, core read latency in cycles from `mem_read` to valid `mem_dout`

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted on `cmd_valid && cmd_ready`.
- `cmd_op` in 1: 0 = load, 1 = unload.
- `cmd_row_base` in AW: first row.
- `cmd_row_count` in AW: number of rows.
- `s_valid` in 1, `s_ready` out 1, `s_data` in WIDTH: load stream.
- `m_valid` out 1, `m_ready` in 1, `m_data` out WIDTH: unload stream.
- `m_last` out 1: high on the final word of the unload.
- `mem_read`, `mem_write` out 1: core strobes.
- `mem_addr` out LANES*AW: same row replicated in every lane.
- `mem_din` out LANES*WIDTH: row to the core `din`.
- `mem_dout` in LANES*WIDTH: row from the core `dout`.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse coincident with `done` for a rejected command.

## Operation
- FSM states: IDLE, FILL, WRITE, READ, WAIT, DRAIN, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On accept, latch op, base and count; clear the word index k and row offset j.
  - If `cmd_row_count`==0: go to DONE with `err`=0.
  - If `base+count > ROWS`: compute in AW+1 bits; go to DONE with `err`=1. No memory access is made.
  - Otherwise go to FILL (load) or READ (unload).
- **Lane packing:** word k of a row maps to lane k, bits [(k+1)*WIDTH-1 -: WIDTH]. Word 0 is lane 0.
- **FILL**
  - `s_ready`=1; each accepted word is written into lane k of the row buffer, then k increments.
  - On acceptance of word LANES-1, go to WRITE.
- **WRITE**
  - `mem_write`=1 for exactly one cycle.
  - `mem_addr`={LANES{base+j}}; `mem_din` = row buffer.
  - j increments, k clears.
  - Next state is FILL if j+1 < count, else DONE.
- **READ**
  - `mem_read`=1 for one cycle with `mem_addr`={LANES{base+j}}.
  - `mem_addr` is held until capture.
  - Go to WAIT.
- **WAIT**
  - Lasts READ_LAT cycles.
  - On the last WAIT edge, `mem_dout` is captured into the row buffer and k clears.
  - Go to DRAIN.
- **DRAIN**
  - `m_valid`=1, `m_data` = lane k of the row buffer; k increments on handshake.
  - `m_last`=1 when k==LANES-1 and j==count-1.
  - After word LANES-1 is accepted: j increments; next state is READ if rows remain, else DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- `mem_read` and `mem_write` are never high together. At most one memory strobe is issued per row.
- `m_data` and `m_last` are held stable while `m_valid && !m_ready`.
- Input is not accepted outside FILL: `s_ready`=0.
- Counters:
  - k is $clog2(LANES) bits and wraps to 0 after LANES-1.
  - j is AW bits.
  - Row address `base+j` is truncated to AW bits; it cannot overflow because of the range check.

## Timing
- **Reset values:** all outputs 0 except `cmd_ready`=1. State is IDLE and the row buffer is cleared.
- **Reset mid-operation:** asserting `reset` low at any time returns to IDLE immediately.
  - The partial row is discarded and no further strobes are issued.
  - No `done` pulse is produced for the aborted command.
- **Load latency** (full-rate stream): count*(LANES+1) cycles after accept to the last `mem_write`. `done` follows one cycle later.
- **Unload latency:**
  - First `m_valid` comes 1+READ_LAT cycles after entering READ.
  - Each row costs 1+READ_LAT+LANES cycles at full `m_ready`.
  - `done` comes one cycle after the `m_last` handshake.
- **Stalls:** `s_valid` or `m_ready` low freezes k and the state. Stall length is unbounded.
- **Command acceptance:** a new command is accepted only in IDLE. A `cmd_valid` held through DONE is accepted in the following IDLE cycle.

## Test plan
- **Load, small config** (LANES=4, ROWS=3, READ_LAT=2): base 0, count 3, words 0x00..0x0B at full rate.
  - Three `mem_write` pulses at cycles 5, 10 and 15 after accept.
  - Row 1 `mem_din` = {0x07,0x06,0x05,0x04}, `mem_addr`={4{8'd1}}.
  - `done` at cycle 16.
- **Unload with random `m_ready` backpressure** from a behavioural core model preloaded with row r lane k = 0x100*r+k: base 1, count 2.
  - Stream is 0x100,0x101,0x102,0x103,0x200,…,0x203.
  - `m_last` only on 0x203; data stable during stalls.
- **Default parameters:** full 85×257 load from memory_data.mem, then unload. Output matches input word for word with 0 mismatches.
- **Rejected commands:**
  - base 2, count 2 (ROWS=3) → `done`+`err` one cycle after accept, no strobes.
  - count 0 → `done` with `err`=0.
- **Reset mid-load:** assert `reset` low during FILL of row 1. No `mem_write` for row 1, `busy`=0, `cmd_ready`=1.
- **Back-to-back commands:** a load command immediately followed by an unload (`cmd_valid` held). The unload is accepted the cycle after `done`; `mem_read` and `mem_write` never overlap.

Source files
------------

// File: rtl/ntt_row_streamer_if.sv
// Command, word-stream and lane-parallel core-memory signals of ntt_row_streamer.
// The streamer uses the slave modport; the host/DMA side uses master.
interface ntt_row_streamer_if #(
    parameter int LANES = 257,
    parameter int WIDTH = 32,
    parameter int AW    = 8
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_op;
    logic [AW-1:0]          cmd_row_base;
    logic [AW-1:0]          cmd_row_count;

    logic                   s_valid;
    logic                   s_ready;
    logic [WIDTH-1:0]       s_data;

    logic                   m_valid;
    logic                   m_ready;
    logic [WIDTH-1:0]       m_data;
    logic                   m_last;

    logic                   mem_read;
    logic                   mem_write;
    logic [LANES*AW-1:0]    mem_addr;
    logic [LANES*WIDTH-1:0] mem_din;
    logic [LANES*WIDTH-1:0] mem_dout;

    modport slave (
        input  cmd_valid, cmd_op, cmd_row_base, cmd_row_count,
        output cmd_ready,
        input  s_valid, s_data,
        output s_ready,
        output m_valid, m_data, m_last,
        input  m_ready,
        output mem_read, mem_write, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output cmd_valid, cmd_op, cmd_row_base, cmd_row_count,
        input  cmd_ready,
        output s_valid, s_data,
        input  s_ready,
        input  m_valid, m_data, m_last,
        output m_ready,
        input  mem_read, mem_write, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/ntt_row_streamer.sv
// Word-serial <-> row-parallel bridge for the NTT core memory port: loads rows from
// a valid/ready stream and unloads rows back to a stream over a checked row window.
module ntt_row_streamer #(
    parameter int LANES    = 257,
    parameter int ROWS     = 85,
    parameter int WIDTH    = 32,
    parameter int AW       = 8,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    ntt_row_streamer_if.slave bus,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int              KW     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int              WW     = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [KW-1:0]   K_LAST = KW'(LANES - 1);
    localparam logic [WW-1:0]   W_LAST = WW'(READ_LAT - 1);
    localparam logic [AW:0]     ROWS_X = (AW+1)'(ROWS);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_WRITE, S_READ, S_WAIT, S_DRAIN, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          base_q, base_d;
    logic [AW-1:0]          count_q, count_d;
    logic [AW-1:0]          j_q, j_d;
    logic [KW-1:0]          k_q, k_d;
    logic [WW-1:0]          w_q, w_d;
    logic                   err_q, err_d;
    logic [LANES*WIDTH-1:0] row_q, row_d;

    logic                   cmd_ready, s_ready, m_valid, mem_read, mem_write, done;
    logic [KW-1:0]          k_inc;
    logic [AW-1:0]          row_addr;
    logic                   last_lane, last_row, range_bad;

    assign last_lane = (k_q == K_LAST);
    assign k_inc     = last_lane ? '0 : k_q + 1'b1;
    // The current row j is the final one of the window.
    assign last_row  = ({1'b0, j_q} + 1'b1) >= {1'b0, count_q};
    assign row_addr  = base_q + j_q;
    assign range_bad = ({1'b0, bus.cmd_row_base} + {1'b0, bus.cmd_row_count}) > ROWS_X;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the row buffer is ordinary flops, not a RAM, so it is cleared by reset like the rest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            count_q <= '0;
            j_q     <= '0;
            k_q     <= '0;
            w_q     <= '0;
            err_q   <= 1'b0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            j_q     <= j_d;
            k_q     <= k_d;
            w_q     <= w_d;
            err_q   <= err_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        base_d    = base_q;
        count_d   = count_q;
        j_d       = j_q;
        k_d       = k_q;
        w_d       = w_q;
        err_d     = err_q;
        row_d     = row_q;
        cmd_ready = 1'b0;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    base_d  = bus.cmd_row_base;
                    count_d = bus.cmd_row_count;
                    j_d     = '0;
                    k_d     = '0;
                    err_d   = 1'b0;
                    if (bus.cmd_row_count == '0) begin
                        state_d = S_DONE;
                    end else if (range_bad) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = bus.cmd_op ? S_READ : S_FILL;
                    end
                end
            end
            S_FILL: begin
                s_ready = 1'b1;
                if (bus.s_valid) begin
                    row_d[k_q*WIDTH +: WIDTH] = bus.s_data;
                    k_d = k_inc;
                    if (last_lane) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_write = 1'b1;
                j_d       = j_q + 1'b1;
                k_d       = '0;
                state_d   = last_row ? S_DONE : S_FILL;
            end
            S_READ: begin
                mem_read = 1'b1;
                w_d      = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // Address stays on row_addr until the core's data is captured here.
                if (w_q == W_LAST) begin
                    row_d   = bus.mem_dout;
                    k_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    w_d = w_q + 1'b1;
                end
            end
            S_DRAIN: begin
                m_valid = 1'b1;
                if (bus.m_ready) begin
                    k_d = k_inc;
                    if (last_lane) begin
                        j_d     = j_q + 1'b1;
                        state_d = last_row ? S_DONE : S_READ;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.s_ready   = s_ready;
    assign bus.m_valid   = m_valid;
    assign bus.m_data    = row_q[k_q*WIDTH +: WIDTH];
    assign bus.m_last    = (state_q == S_DRAIN) && last_lane && last_row;
    assign bus.mem_read  = mem_read;
    assign bus.mem_write = mem_write;
    assign bus.mem_addr  = {LANES{row_addr}};
    assign bus.mem_din   = row_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done;
    assign err_o         = (state_q == S_DONE) && err_q;
endmodule

// File: tb/tb_ntt_row_streamer.sv
// Bench for ntt_row_streamer on a small 4-lane, 3-row configuration with a
// behavioural core memory, stream driver/sink and event recorders.
module tb_ntt_row_streamer;
    localparam int L  = 4;
    localparam int R  = 3;
    localparam int W  = 32;
    localparam int A  = 8;
    localparam int RL = 2;
    localparam int BW = L * W;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ntt_row_streamer_if #(.LANES(L), .WIDTH(W), .AW(A)) bus ();
    logic busy, done, err;

    ntt_row_streamer #(.LANES(L), .ROWS(R), .WIDTH(W), .AW(A), .READ_LAT(RL)) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy_o(busy), .done_o(done), .err_o(err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core memory: writes land on the edge, reads return RL edges after the strobe.
    logic [BW-1:0] core_mem [R];
    logic [BW-1:0] rd_pipe  [RL];
    always @(posedge clk) begin
        if (bus.mem_write && int'(bus.mem_addr[A-1:0]) < R)
            core_mem[bus.mem_addr[A-1:0]] <= bus.mem_din;
        rd_pipe[0] <= (bus.mem_read && int'(bus.mem_addr[A-1:0]) < R) ?
                      core_mem[bus.mem_addr[A-1:0]] : {L{32'hDEADBEEF}};
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_dout = rd_pipe[RL-1];

    int              wr_cyc[$];
    logic [A*L-1:0]  wr_addr[$];
    logic [BW-1:0]   wr_din[$];
    int              rd_cyc[$];
    logic [A*L-1:0]  rd_addr[$];
    int              done_cyc[$];
    logic            done_err[$];
    int              out_cyc[$];
    logic [W-1:0]    out_data[$];
    logic            out_last[$];
    int              overlap  = 0;
    int              unstable = 0;
    logic            stall_prev = 1'b0;
    logic [W-1:0]    prev_data;
    logic            prev_last;

    always @(negedge clk) begin
        if (bus.mem_write) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(bus.mem_addr);
            wr_din.push_back(bus.mem_din);
        end
        if (bus.mem_read) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(bus.mem_addr);
        end
        if (bus.mem_read && bus.mem_write) overlap++;
        if (done) begin
            done_cyc.push_back(cyc);
            done_err.push_back(err);
        end
        if (bus.m_valid && bus.m_ready) begin
            out_cyc.push_back(cyc);
            out_data.push_back(bus.m_data);
            out_last.push_back(bus.m_last);
        end
        if (stall_prev && (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last))
            unstable++;
        stall_prev = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;
    end

    bit sink_rand = 1'b0;
    always @(posedge clk) begin
        #1;
        bus.m_ready = sink_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] pack(input logic [W-1:0] q[$], input int off);
        logic [BW-1:0] v;
        v = '0;
        for (int k = 0; k < L; k++) v[k*W +: W] = q[off + k];
        return v;
    endfunction

    function automatic logic [A*L-1:0] rep(input int r);
        logic [A*L-1:0] v;
        for (int k = 0; k < L; k++) v[k*A +: A] = A'(r);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input bit op, input int base, input int cnt, output int acc);
        int t;
        bit ok;
        t  = 0;
        ok = 1'b0;
        bus.cmd_valid     = 1'b1;
        bus.cmd_op        = op;
        bus.cmd_row_base  = A'(base);
        bus.cmd_row_count = A'(cnt);
        while (!ok && t < 300) begin
            @(negedge clk);
            ok = bus.cmd_ready;
            t++;
        end
        acc = cyc;
        if (!ok) check("cmd_timeout", 0, 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic push_words(input logic [W-1:0] q[$], input bit gaps);
        foreach (q[i]) begin
            int t;
            bit ok;
            t  = 0;
            ok = 1'b0;
            if (gaps) while ($urandom_range(0, 2) == 0) begin
                bus.s_valid = 1'b0;
                tick();
            end
            bus.s_valid = 1'b1;
            bus.s_data  = q[i];
            while (!ok && t < 300) begin
                @(negedge clk);
                ok = bus.s_ready;
                t++;
            end
            tick();
            bus.s_valid = 1'b0;
            if (!ok) begin
                check("s_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int t;
        t = 0;
        while (done_cyc.size() < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (done_cyc.size() < target) check({tag, "_timeout"}, 0, 1);
        tick();
    endtask

    initial begin
        logic [W-1:0] words[$];
        int acc, acc2, w0, r0, d0, o0;

        bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0;
        bus.cmd_row_base = '0; bus.cmd_row_count = '0;
        bus.s_valid = 1'b0; bus.s_data = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_flags", {done, err, bus.s_ready, bus.m_valid, bus.m_last,
                            bus.mem_read, bus.mem_write}, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_din", bus.mem_din, 0);
        check("rst_m_data", bus.m_data, 0);
        tick();
        reset = 1'b1;
        tick();

        // Full-rate load of words 0x00..0x0B into rows 0..2.
        words = {};
        for (int i = 0; i < 3 * L; i++) words.push_back(W'(i));
        w0 = wr_cyc.size(); r0 = rd_cyc.size(); d0 = done_cyc.size();
        send_cmd(1'b0, 0, 3, acc);
        push_words(words, 1'b0);
        wait_done("t1", d0 + 1, 100);
        check("t1_nwr", wr_cyc.size() - w0, 3);
        for (int r = 0; r < 3; r++) begin
            check("t1_wr_cyc", wr_cyc[w0+r] - acc, 5 * (r + 1));
            check("t1_wr_addr", wr_addr[w0+r], rep(r));
            check("t1_wr_din", wr_din[w0+r], pack(words, L * r));
        end
        check("t1_row1_din", wr_din[w0+1], {32'h7, 32'h6, 32'h5, 32'h4});
        check("t1_row1_addr", wr_addr[w0+1], {4{8'd1}});
        check("t1_done_cyc", done_cyc[d0] - acc, 16);
        check("t1_err", done_err[d0], 0);
        check("t1_no_read", rd_cyc.size() - r0, 0);

        // Load row r lane k = 0x100*r+k with random source gaps.
        words = {};
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < L; k++) words.push_back(W'(32'h100 * r + k));
        w0 = wr_cyc.size(); d0 = done_cyc.size();
        send_cmd(1'b0, 0, 3, acc);
        push_words(words, 1'b1);
        wait_done("t2", d0 + 1, 400);
        check("t2_nwr", wr_cyc.size() - w0, 3);
        for (int r = 0; r < 3; r++) begin
            check("t2_wr_addr", wr_addr[w0+r], rep(r));
            check("t2_wr_din", wr_din[w0+r], pack(words, L * r));
        end

        // Unload rows 1..2 under random m_ready backpressure.
        w0 = wr_cyc.size(); r0 = rd_cyc.size(); d0 = done_cyc.size(); o0 = out_data.size();
        sink_rand = 1'b1;
        send_cmd(1'b1, 1, 2, acc);
        wait_done("t3", d0 + 1, 600);
        sink_rand = 1'b0;
        check("t3_nout", out_data.size() - o0, 2 * L);
        for (int i = 0; i < 2 * L; i++) begin
            check("t3_data", out_data[o0+i], 32'h100 * (1 + i / L) + i % L);
            check("t3_last", out_last[o0+i], (i == 2 * L - 1));
        end
        check("t3_nrd", rd_cyc.size() - r0, 2);
        check("t3_rd_addr", rd_addr[r0+1], rep(2));
        check("t3_no_wr", wr_cyc.size() - w0, 0);
        check("t3_done_cyc", done_cyc[d0] - out_cyc[o0 + 2*L - 1], 1);
        check("t3_stable", unstable, 0);

        // Rejected windows and empty command: done one cycle after accept, no strobes.
        w0 = wr_cyc.size(); r0 = rd_cyc.size(); d0 = done_cyc.size();
        send_cmd(1'b0, 2, 2, acc);
        wait_done("t4a", d0 + 1, 20);
        check("t4a_done_cyc", done_cyc[d0] - acc, 1);
        check("t4a_err", done_err[d0], 1);
        send_cmd(1'b1, 255, 1, acc);
        wait_done("t4b", d0 + 2, 20);
        check("t4b_done_cyc", done_cyc[d0+1] - acc, 1);
        check("t4b_err", done_err[d0+1], 1);
        send_cmd(1'b0, 0, 0, acc);
        wait_done("t4c", d0 + 3, 20);
        check("t4c_done_cyc", done_cyc[d0+2] - acc, 1);
        check("t4c_err", done_err[d0+2], 0);
        check("t4_no_strobes", {wr_cyc.size() - w0, rd_cyc.size() - r0}, 0);

        // Window ending exactly at the last row, full-rate sink.
        o0 = out_data.size(); d0 = done_cyc.size();
        send_cmd(1'b1, 2, 1, acc);
        wait_done("t4d", d0 + 1, 50);
        check("t4d_first_cyc", out_cyc[o0] - acc, 2 + RL);
        check("t4d_done_cyc", done_cyc[d0] - acc, 2 + RL + L);
        check("t4d_err", done_err[d0], 0);
        for (int k = 0; k < L; k++) check("t4d_data", out_data[o0+k], 32'h200 + k);

        // Random load with an unload command held pending, then full-rate readback.
        words = {};
        for (int i = 0; i < 3 * L; i++) words.push_back($urandom);
        d0 = done_cyc.size(); o0 = out_data.size();
        send_cmd(1'b0, 0, 3, acc);
        bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1;
        bus.cmd_row_base = 8'd0; bus.cmd_row_count = 8'd3;
        push_words(words, 1'b0);
        send_cmd(1'b1, 0, 3, acc2);
        wait_done("t5", d0 + 2, 300);
        check("t5_load_done", done_cyc[d0] - acc, 16);
        check("t5_b2b_accept", acc2 - done_cyc[d0], 1);
        check("t5_nout", out_data.size() - o0, 3 * L);
        for (int i = 0; i < 3 * L; i++) check("t5_data", out_data[o0+i], words[i]);
        check("t5_first_cyc", out_cyc[o0] - acc2, 2 + RL);
        check("t5_last_cyc", out_cyc[o0 + 3*L - 1] - acc2, 3 * (1 + RL + L));
        check("t5_last_flag", out_last[o0 + 3*L - 1], 1);
        check("t5_done_cyc", done_cyc[d0+1] - acc2, 1 + 3 * (1 + RL + L));
        check("t5_overlap", overlap, 0);

        // Reset during FILL of row 1 aborts the command without strobes or done.
        words = {};
        for (int i = 0; i < L + 2; i++) words.push_back($urandom);
        w0 = wr_cyc.size(); d0 = done_cyc.size();
        send_cmd(1'b0, 0, 3, acc);
        push_words(words, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_cmd_ready", bus.cmd_ready, 1);
        tick(); tick();
        reset = 1'b1;
        repeat (20) tick();
        check("t6_nwr", wr_cyc.size() - w0, 1);
        check("t6_no_done", done_cyc.size() - d0, 0);
        check("t6_idle", {busy, bus.cmd_ready}, 2'b01);
        check("overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
